// File: rtl/jk_reg_bank.sv
// Multi-mode (JK/T/D/SR) register bank with parallel load, clock enable,
// per-bit change pulses, a saturating change counter and a sticky SR error flag.
module jk_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] chg,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             err
);

  localparam logic [1:0]       MODE_JK = 2'b00;
  localparam logic [1:0]       MODE_T  = 2'b01;
  localparam logic [1:0]       MODE_D  = 2'b10;
  localparam logic [1:0]       MODE_SR = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] chg_r;
  logic [CNT_W-1:0] cnt_r;
  logic             err_r;
  logic [WIDTH-1:0] q_next_s;
  logic             illegal_s;
  logic             changed_s;

  // Next-state selection: load beats enable; SR 11 holds its bit and flags an error.
  always_comb begin
    q_next_s  = q_r;
    illegal_s = 1'b0;
    if (load) begin
      q_next_s = d;
    end else if (en) begin
      case (mode)
        MODE_JK: q_next_s = (j & ~q_r) | (~k & q_r);
        MODE_T:  q_next_s = q_r ^ j;
        MODE_D:  q_next_s = j;
        MODE_SR: begin
          q_next_s  = (j & ~k) | (q_r & (j | ~k));
          illegal_s = |(j & k);
        end
        default: q_next_s = q_r;
      endcase
    end else begin
      q_next_s = q_r;
    end
  end

  // Any bit difference counts as a single change event.
  always_comb begin
    changed_s = (q_next_s != q_r);
  end

  // State, change pulse, saturating counter and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= RST_VAL;
      chg_r <= '0;
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      q_r   <= q_next_s;
      chg_r <= q_next_s ^ q_r;
      if (changed_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
      err_r <= err_r | illegal_s;
    end
  end

  assign q       = q_r;
  assign qn      = ~q_r;
  assign chg     = chg_r;
  assign chg_cnt = cnt_r;
  assign err     = err_r;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank: directed scenarios then random traffic,
// checked against a per-bit behavioural model.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [7:0] d, j, k;
  logic [1:0] mode;
  logic [7:0] q, qn, chg, cnt8;
  logic       err;
  logic [7:0] q2, qn2, chg2;
  logic [1:0] cnt2;
  logic       err2;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .mode(mode), .j(j), .k(k),
    .q(q), .qn(qn), .chg(chg), .chg_cnt(cnt8), .err(err));

  jk_reg_bank #(.WIDTH(8), .RST_VAL(8'hA5), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d), .mode(mode), .j(j), .k(k),
    .q(q2), .qn(qn2), .chg(chg2), .chg_cnt(cnt2), .err(err2));

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] qn;
    logic [7:0] chg;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    logic       err;
    logic [7:0] q2;
    logic       err2;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // reference state
  logic [7:0] mq;
  int         mcnt8, mcnt2;
  logic       merr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus at the negedge and push the modelled outcome.
  task automatic step(input logic r, input logic ld, input logic e, input logic [1:0] m,
                      input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] dd);
    logic [7:0] nq;
    exp_t       x;
    @(negedge clk);
    rst = r; load = ld; en = e; mode = m; j = jj; k = kk; d = dd;
    if (r) begin
      nq = 8'hA5;
      x.chg = 8'h00;
      mcnt8 = 0; mcnt2 = 0; merr = 1'b0;
    end else begin
      nq = mq;
      if (ld) begin
        nq = dd;
      end else if (e) begin
        for (int i = 0; i < 8; i++) begin
          int jk;
          jk = jj[i] * 2 + kk[i];
          case (m)
            2'd0: nq[i] = (jk == 0) ? mq[i] : (jk == 1) ? 1'b0 : (jk == 2) ? 1'b1 : !mq[i];
            2'd1: nq[i] = jj[i] ? !mq[i] : mq[i];
            2'd2: nq[i] = jj[i];
            default: begin
              nq[i] = (jk == 1) ? 1'b0 : (jk == 2) ? 1'b1 : mq[i];
              if (jk == 3) merr = 1'b1;
            end
          endcase
        end
      end
      x.chg = nq ^ mq;
      if (nq != mq) begin
        if (mcnt8 < 255) mcnt8++;
        if (mcnt2 < 3) mcnt2++;
      end
    end
    mq = nq;
    x.q = mq; x.qn = ~mq; x.cnt8 = mcnt8[7:0]; x.cnt2 = mcnt2[1:0];
    x.err = merr; x.q2 = mq; x.err2 = merr;
    sb.push_back(x);
  endtask

  // Monitor: every rising edge produces an update; compare it after the edge settles.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("q", {24'h0, q}, {24'h0, x.q});
        check("qn", {24'h0, qn}, {24'h0, x.qn});
        check("chg", {24'h0, chg}, {24'h0, x.chg});
        check("chg_cnt", {24'h0, cnt8}, {24'h0, x.cnt8});
        check("err", {31'h0, err}, {31'h0, x.err});
        check("chg_cnt_w2", {30'h0, cnt2}, {30'h0, x.cnt2});
        check("q_w2", {24'h0, q2}, {24'h0, x.q2});
        check("err_w2", {31'h0, err2}, {31'h0, x.err2});
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; mode = 2'b00; j = 8'h00; k = 8'h00; d = 8'h00;
    mq = 8'hA5; mcnt8 = 0; mcnt2 = 0; merr = 1'b0;

    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);

    // JK: set, toggle, hold
    step(1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 2'd0, 8'hF0, 8'h0F, 8'h00);
    step(1'b0, 1'b0, 1'b1, 2'd0, 8'hFF, 8'hFF, 8'h00);
    step(1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00);

    // T: toggle bit0 four times, disable, then load with en low
    step(1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 2'd1, 8'h01, 8'hFF, 8'h00);
    step(1'b0, 1'b0, 1'b0, 2'd1, 8'h01, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b0, 2'd1, 8'h01, 8'h00, 8'h3C);

    // SR: partial illegal word, sticky err, load overriding illegal pattern
    step(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 2'd3, 8'h03, 8'h01, 8'h00);
    step(1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 2'd3, 8'hFF, 8'hFF, 8'h00);
    step(1'b0, 1'b1, 1'b1, 2'd3, 8'hFF, 8'hFF, 8'h81);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    step(1'b0, 1'b1, 1'b1, 2'd3, 8'hFF, 8'hFF, 8'h5A);

    // D mode and counter saturation on the narrow instance
    step(1'b0, 1'b0, 1'b1, 2'd2, 8'hC3, 8'hFF, 8'h00);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 2'd1, 8'h01, 8'h00, 8'h00);
    step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);

    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           8'($urandom), 8'($urandom), 8'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
